// File: rtl/bit_decomposer.sv
// Splits a captured 32-bit word into one-hot elements, lowest set bit first,
// streamed over a valid/ready handshake with a done pulse at the end.
module bit_decomposer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_mask,
  output logic        out_last,
  output logic        done,
  output logic [5:0]  count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] remaining;
  logic [31:0] remaining_nx;
  logic [5:0]  count_nx;
  logic [4:0]  lsb_idx;
  logic [31:0] lsb_mask;
  logic        single;
  logic        xfer;

  // Downward scan so the lowest set bit wins.
  always_comb begin
    lsb_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (remaining[i]) lsb_idx = i[4:0];
    end
  end

  assign lsb_mask = 32'd1 << lsb_idx;
  assign single   = (remaining & (remaining - 32'd1)) == 32'd0;
  assign xfer     = (state == S_SCAN) && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      count     <= count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    count_nx     = count;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          remaining_nx = data_in;
          count_nx     = '0;
          state_nx     = (data_in != 32'd0) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        if (xfer) begin
          remaining_nx = remaining & ~lsb_mask;
          count_nx     = count + 6'd1;
          if (single) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Element fields are forced to zero outside SCAN.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_mask  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_SCAN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_index = lsb_idx;
        out_mask  = lsb_mask;
        out_last  = single;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_decomposer.sv
// Self-checking bench for bit_decomposer: vector table, random words
// against a set-bit list model, and a mid-scan reset sequence.
module tb_bit_decomposer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_mask;
  logic        out_last;
  logic        done;
  logic [5:0]  count;

  int tests = 0;
  int fails = 0;

  bit_decomposer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .done      (done),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    int          mode;
    bit          hold;
    int          n;
    int          first;
    int          last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: stall first 3 cycles.
  task automatic run_word(input logic [31:0] d, input int mode,
                          input bit hold, output int n_el,
                          output int first_idx, output int last_idx);
    int  exp_q[$];
    int  total;
    int  cyc;
    int  stall;
    bit  got_done;
    bit  rdy;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) exp_q.push_back(i);
    end
    total     = exp_q.size();
    n_el      = 0;
    first_idx = -1;
    last_idx  = -1;
    cyc       = 0;
    stall     = 0;
    got_done  = 1'b0;
    @(negedge clock);
    start   = 1'b1;
    data_in = d;
    @(negedge clock);
    start   = hold;
    data_in = hold ? 32'hFFFF_0000 : $urandom;
    while (!got_done && cyc < 200) begin
      if (exp_q.size() > 0) begin
        chk("valid", {31'd0, out_valid}, 32'd1);
        chk("busy_scan", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
        chk("index", {27'd0, out_index}, exp_q[0]);
        chk("mask", out_mask, 32'd1 << exp_q[0]);
        chk("last", {31'd0, out_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else begin
          rdy = (stall >= 3);
          stall++;
        end
        out_ready = rdy;
        if (rdy) begin
          if (first_idx < 0) first_idx = exp_q[0];
          last_idx = exp_q[0];
          n_el++;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("done", {31'd0, done}, 32'd1);
        chk("valid_done", {31'd0, out_valid}, 32'd0);
        chk("zero_fields", {out_index, out_mask[26:0], out_last}, 33'd0);
        got_done  = 1'b1;
        start     = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
      cyc++;
      if (!hold) data_in = $urandom;
      @(negedge clock);
    end
    if (!got_done) chk("timeout", 32'd0, 32'd1);
    chk("done_once", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("count", {26'd0, count}, total);
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("count_hold", {26'd0, count}, total);
  endtask

  initial begin
    vec_t vecs[$];
    int n, f, l, exp_n, exp_f, exp_l;
    logic [31:0] w;

    vecs.push_back('{32'h0000_0000, 0, 1'b0, 0, -1, -1});
    vecs.push_back('{32'h8000_0001, 0, 1'b0, 2, 0, 31});
    vecs.push_back('{32'hFFFF_FFFF, 0, 1'b0, 32, 0, 31});
    vecs.push_back('{32'h0000_0A00, 2, 1'b0, 2, 9, 11});
    vecs.push_back('{32'h0000_0010, 1, 1'b0, 1, 4, 4});
    vecs.push_back('{32'h0000_0003, 0, 1'b1, 2, 0, 1});
    vecs.push_back('{32'h4000_0000, 2, 1'b0, 1, 30, 30});

    reset     = 1'b1;
    start     = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {26'd0, count}, 32'd0);
    chk("rst_fields", {out_index, out_mask[26:0], out_last}, 33'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[k]) begin
      run_word(vecs[k].d, vecs[k].mode, vecs[k].hold, n, f, l);
      chk("vec_n", n, vecs[k].n);
      chk("vec_first", f, vecs[k].first);
      chk("vec_last", l, vecs[k].last);
    end

    for (int r = 0; r < 25; r++) begin
      w = (r % 3 == 0) ? $urandom : ($urandom & $urandom & $urandom);
      exp_n = $countones(w);
      exp_f = -1;
      exp_l = -1;
      for (int i = 0; i < 32; i++) begin
        if (w[i]) begin
          if (exp_f < 0) exp_f = i;
          exp_l = i;
        end
      end
      run_word(w, 1 + (r % 2), 1'($urandom_range(0, 1)), n, f, l);
      chk("rnd_n", n, exp_n);
      chk("rnd_first", f, exp_f);
      chk("rnd_last", l, exp_l);
    end

    // Reset after the second transfer of 0xF aborts the word.
    @(negedge clock);
    start     = 1'b1;
    data_in   = 32'h0000_000F;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("rs_idx0", {27'd0, out_index}, 32'd0);
    @(negedge clock);
    chk("rs_idx1", {27'd0, out_index}, 32'd1);
    @(negedge clock);
    chk("rs_idx2", {27'd0, out_index}, 32'd2);
    chk("rs_cnt2", {26'd0, count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rs_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_fields", {out_index, out_mask[26:0], out_last}, 33'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_count", {26'd0, count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rs_no_done", {31'd0, done}, 32'd0);
      chk("rs_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
    end
    run_word(32'h0000_0010, 0, 1'b0, n, f, l);
    chk("rs_fresh_n", n, 1);
    chk("rs_fresh_idx", f, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
